tb_axi_slave_mem: RTL

TB_AXI_SLAVE_MEM -- requirements
Module: tb_axi_slave_mem

---
 rtl/tb_axi_pkg.sv | 18 +
 rtl/tb_axi_stall_gen.sv | 17 +
 rtl/tb_axi_slave_mem.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/tb_axi_pkg.sv
// Shared response codes and FSM state types for the AXI slave memory model.
package tb_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } r_state_t;

endpackage

// File: rtl/tb_axi_stall_gen.sv
// Free-running 2-bit counter; stall is asserted on every fourth cycle.
module tb_axi_stall_gen (
  input  logic clk,
  input  logic rst_n,
  output logic stall
);

  logic [1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else        cnt <= cnt + 2'd1;
  end

  assign stall = (cnt == 2'b11);

endmodule

// File: rtl/tb_axi_slave_mem.sv
// AXI slave backed by a word memory with independent INCR read/write FSMs.
// Optional stall injection on WREADY/RVALID when TB_AXI_SLAVE_STALL_EN is defined.
module tb_axi_slave_mem
  import tb_axi_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ID_W      = 1,
  parameter int unsigned MEM_WORDS = 1024
) (
  input  logic                ACLK,
  input  logic                ARESETN,
  input  logic [ID_W-1:0]     M_AXI_AWID,
  input  logic [31:0]         M_AXI_AWADDR,
  input  logic [7:0]          M_AXI_AWLEN,
  input  logic                M_AXI_AWVALID,
  output logic                M_AXI_AWREADY,
  input  logic [DATA_W-1:0]   M_AXI_WDATA,
  input  logic [DATA_W/8-1:0] M_AXI_WSTRB,
  input  logic                M_AXI_WLAST,
  input  logic                M_AXI_WVALID,
  output logic                M_AXI_WREADY,
  output logic [ID_W-1:0]     M_AXI_BID,
  output logic [1:0]          M_AXI_BRESP,
  output logic                M_AXI_BVALID,
  input  logic                M_AXI_BREADY,
  input  logic [ID_W-1:0]     M_AXI_ARID,
  input  logic [31:0]         M_AXI_ARADDR,
  input  logic [7:0]          M_AXI_ARLEN,
  input  logic                M_AXI_ARVALID,
  output logic                M_AXI_ARREADY,
  output logic [ID_W-1:0]     M_AXI_RID,
  output logic [DATA_W-1:0]   M_AXI_RDATA,
  output logic [1:0]          M_AXI_RRESP,
  output logic                M_AXI_RLAST,
  output logic                M_AXI_RVALID,
  input  logic                M_AXI_RREADY
);

  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned LSB   = $clog2(BYTES);
  localparam int unsigned IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  logic [DATA_W-1:0] mem [MEM_WORDS] = '{default: '0};

  logic stall;

`ifdef TB_AXI_SLAVE_STALL_EN
  tb_axi_stall_gen u_stall (
    .clk   (ACLK),
    .rst_n (ARESETN),
    .stall (stall)
  );
`else
  assign stall = 1'b0;
`endif

  w_state_t         w_state;
  logic [31:0]      waddr;
  logic [7:0]       wlen, wbeat;
  logic             werr, wready_q, w_hs, w_in_range, w_beat_err;
  logic [IDX_W-1:0] widx;

  r_state_t         r_state;
  logic [31:0]      raddr;
  logic [7:0]       rlen, rbeat;
  logic             rvalid_q, r_hs, r_in_range;
  logic [IDX_W-1:0] ridx;

  always_comb begin
    w_in_range   = (waddr >> LSB) < MEM_WORDS;
    widx         = IDX_W'(waddr >> LSB);
    M_AXI_WREADY = wready_q & ~stall;
    w_hs         = M_AXI_WVALID & M_AXI_WREADY;
    // Length error covers both early WLAST and beats continuing past AWLEN.
    w_beat_err   = !w_in_range || (M_AXI_WLAST ? (wbeat != wlen) : (wbeat == wlen));

    r_in_range   = (raddr >> LSB) < MEM_WORDS;
    ridx         = IDX_W'(raddr >> LSB);
    M_AXI_RVALID = rvalid_q & ~stall;
    r_hs         = M_AXI_RVALID & M_AXI_RREADY;
    M_AXI_RDATA  = r_in_range ? mem[ridx] : '0;
    M_AXI_RRESP  = (rvalid_q && !r_in_range) ? RESP_SLVERR : RESP_OKAY;
    M_AXI_RLAST  = rvalid_q && (rbeat == rlen);
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      w_state       <= W_IDLE;
      M_AXI_AWREADY <= 1'b0;
      wready_q      <= 1'b0;
      M_AXI_BVALID  <= 1'b0;
      M_AXI_BRESP   <= RESP_OKAY;
      M_AXI_BID     <= '0;
      waddr         <= '0;
      wlen          <= '0;
      wbeat         <= '0;
      werr          <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          M_AXI_AWREADY <= 1'b1;
          if (M_AXI_AWVALID && M_AXI_AWREADY) begin
            M_AXI_AWREADY <= 1'b0;
            wready_q      <= 1'b1;
            M_AXI_BID     <= M_AXI_AWID;
            waddr         <= M_AXI_AWADDR;
            wlen          <= M_AXI_AWLEN;
            wbeat         <= '0;
            werr          <= 1'b0;
            w_state       <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            waddr <= waddr + BYTES;
            wbeat <= wbeat + 8'd1;
            if (M_AXI_WLAST) begin
              wready_q     <= 1'b0;
              M_AXI_BVALID <= 1'b1;
              M_AXI_BRESP  <= (werr || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
              w_state      <= W_RESP;
            end else begin
              werr <= werr | w_beat_err;
            end
          end
        end
        W_RESP: begin
          if (M_AXI_BVALID && M_AXI_BREADY) begin
            M_AXI_BVALID  <= 1'b0;
            M_AXI_AWREADY <= 1'b1;
            w_state       <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (w_state == W_DATA && w_hs && w_in_range) begin
      for (int unsigned b = 0; b < BYTES; b++) begin
        if (M_AXI_WSTRB[b]) mem[widx][8*b +: 8] <= M_AXI_WDATA[8*b +: 8];
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state       <= R_IDLE;
      M_AXI_ARREADY <= 1'b0;
      rvalid_q      <= 1'b0;
      M_AXI_RID     <= '0;
      raddr         <= '0;
      rlen          <= '0;
      rbeat         <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          M_AXI_ARREADY <= 1'b1;
          if (M_AXI_ARVALID && M_AXI_ARREADY) begin
            M_AXI_ARREADY <= 1'b0;
            rvalid_q      <= 1'b1;
            M_AXI_RID     <= M_AXI_ARID;
            raddr         <= M_AXI_ARADDR;
            rlen          <= M_AXI_ARLEN;
            rbeat         <= '0;
            r_state       <= R_DATA;
          end
        end
        R_DATA: begin
          if (r_hs) begin
            if (M_AXI_RLAST) begin
              rvalid_q      <= 1'b0;
              M_AXI_ARREADY <= 1'b1;
              r_state       <= R_IDLE;
            end else begin
              raddr <= raddr + BYTES;
              rbeat <= rbeat + 8'd1;
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule
